// File: rtl/pa_pkg.sv
// Shared types and default geometry for the parallel-adapter channel sequencer.
package pa_pkg;

  localparam int unsigned PA_NUM_SAMPLES     = 4;
  localparam int unsigned PA_KERNELS_TOTAL   = 6;
  localparam int unsigned PA_FMAP_IMAGE_SIZE = 784;
  localparam int unsigned PA_IMAGE_LENGTH    = 784;
  localparam int unsigned PA_TIMER_W         = 16;

  // Index/address width for a range of n values; never narrower than one bit.
  function automatic int unsigned pa_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PA_IMAGE_ADDR_W = pa_width(PA_NUM_SAMPLES * PA_IMAGE_LENGTH);
  localparam int unsigned PA_MAP_ADDR_W   =
    pa_width(PA_NUM_SAMPLES * PA_KERNELS_TOTAL * PA_FMAP_IMAGE_SIZE);
  localparam int unsigned PA_PARAM_IDX_W  = pa_width(PA_NUM_SAMPLES * PA_KERNELS_TOTAL);

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_LOAD    = 3'd1,
    SEQ_RUN     = 3'd2,
    SEQ_WRITE   = 3'd3,
    SEQ_ADVANCE = 3'd4
  } pa_seq_state_t;

endpackage

// File: rtl/pa_channel_sequencer_if.sv
// Control, handshake and address bundle between the PA sequencer (master) and
// the PA datapath / load / writeback logic (slave).
interface pa_channel_sequencer_if #(
  parameter int unsigned NUM_SAMPLES        = pa_pkg::PA_NUM_SAMPLES,
  parameter int unsigned PA_KERNELS_TOTAL   = pa_pkg::PA_KERNELS_TOTAL,
  parameter int unsigned PA_FMAP_IMAGE_SIZE = pa_pkg::PA_FMAP_IMAGE_SIZE,
  parameter int unsigned PA_IMAGE_LENGTH    = pa_pkg::PA_IMAGE_LENGTH
);
  localparam int unsigned SAMPLE_W  = pa_pkg::pa_width(NUM_SAMPLES);
  localparam int unsigned CHANNEL_W = pa_pkg::pa_width(PA_KERNELS_TOTAL);
  localparam int unsigned IMAGE_W   = pa_pkg::pa_width(NUM_SAMPLES * PA_IMAGE_LENGTH);
  localparam int unsigned MAP_W     =
    pa_pkg::pa_width(NUM_SAMPLES * PA_KERNELS_TOTAL * PA_FMAP_IMAGE_SIZE);
  localparam int unsigned PARAM_W   = pa_pkg::pa_width(NUM_SAMPLES * PA_KERNELS_TOTAL);

  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 run_done;
  logic                 load_req;
  logic                 load_ack;
  logic [IMAGE_W-1:0]   image_base;
  logic [MAP_W-1:0]     map_base;
  logic [PARAM_W-1:0]   param_idx;
  logic                 do_fp;
  logic                 do_bp;
  logic                 done_BP;
  logic                 result_valid;
  logic                 result_ready;
  logic [SAMPLE_W-1:0]  sample_idx;
  logic [CHANNEL_W-1:0] channel_idx;
  logic                 timeout_err;

  modport master (
    input  start, abort, load_ack, done_BP, result_ready,
    output busy, run_done, load_req, image_base, map_base, param_idx,
           do_fp, do_bp, result_valid, sample_idx, channel_idx, timeout_err
  );

  modport slave (
    output start, abort, load_ack, done_BP, result_ready,
    input  busy, run_done, load_req, image_base, map_base, param_idx,
           do_fp, do_bp, result_valid, sample_idx, channel_idx, timeout_err
  );

endinterface

// File: rtl/pa_seq_addr_gen.sv
// Converts (sample, channel) into registered operand base addresses; the
// registers load only when the sequencer enters LOAD.
module pa_seq_addr_gen #(
  parameter int unsigned NUM_SAMPLES        = pa_pkg::PA_NUM_SAMPLES,
  parameter int unsigned PA_KERNELS_TOTAL   = pa_pkg::PA_KERNELS_TOTAL,
  parameter int unsigned PA_FMAP_IMAGE_SIZE = pa_pkg::PA_FMAP_IMAGE_SIZE,
  parameter int unsigned PA_IMAGE_LENGTH    = pa_pkg::PA_IMAGE_LENGTH,
  localparam int unsigned SAMPLE_W  = pa_pkg::pa_width(NUM_SAMPLES),
  localparam int unsigned CHANNEL_W = pa_pkg::pa_width(PA_KERNELS_TOTAL),
  localparam int unsigned IMAGE_W   = pa_pkg::pa_width(NUM_SAMPLES * PA_IMAGE_LENGTH),
  localparam int unsigned MAP_W     =
    pa_pkg::pa_width(NUM_SAMPLES * PA_KERNELS_TOTAL * PA_FMAP_IMAGE_SIZE),
  localparam int unsigned PARAM_W   = pa_pkg::pa_width(NUM_SAMPLES * PA_KERNELS_TOTAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SAMPLE_W-1:0]  sample,
  input  logic [CHANNEL_W-1:0] channel,
  output logic [IMAGE_W-1:0]   image_base,
  output logic [MAP_W-1:0]     map_base,
  output logic [PARAM_W-1:0]   param_idx
);

  // 32-bit intermediate arithmetic; results always fit the narrowed widths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image_base <= '0;
      map_base   <= '0;
      param_idx  <= '0;
    end else if (en) begin
      image_base <= IMAGE_W'(32'(sample) * 32'(PA_IMAGE_LENGTH));
      param_idx  <= PARAM_W'(32'(sample) * 32'(PA_KERNELS_TOTAL) + 32'(channel));
      map_base   <= MAP_W'((32'(sample) * 32'(PA_KERNELS_TOTAL) + 32'(channel))
                           * 32'(PA_FMAP_IMAGE_SIZE));
    end
  end

endmodule

// File: rtl/pa_channel_sequencer.sv
// Walks every (sample, channel) pair through LOAD -> RUN -> WRITE -> ADVANCE.
// Optional RUN watchdog is compiled in with `define PA_SEQ_TIMEOUT_EN.
module pa_channel_sequencer #(
  parameter int unsigned NUM_SAMPLES        = pa_pkg::PA_NUM_SAMPLES,
  parameter int unsigned PA_KERNELS_TOTAL   = pa_pkg::PA_KERNELS_TOTAL,
  parameter int unsigned PA_FMAP_IMAGE_SIZE = pa_pkg::PA_FMAP_IMAGE_SIZE,
  parameter int unsigned PA_IMAGE_LENGTH    = pa_pkg::PA_IMAGE_LENGTH,
  parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
  input logic                    clk,
  input logic                    rst,
  pa_channel_sequencer_if.master bus
);
  import pa_pkg::*;

  localparam int unsigned SAMPLE_W  = pa_width(NUM_SAMPLES);
  localparam int unsigned CHANNEL_W = pa_width(PA_KERNELS_TOTAL);
  localparam int unsigned IMAGE_W   = pa_width(NUM_SAMPLES * PA_IMAGE_LENGTH);
  localparam int unsigned MAP_W     = pa_width(NUM_SAMPLES * PA_KERNELS_TOTAL * PA_FMAP_IMAGE_SIZE);
  localparam int unsigned PARAM_W   = pa_width(NUM_SAMPLES * PA_KERNELS_TOTAL);

  pa_seq_state_t        state, state_next;
  logic [SAMPLE_W-1:0]  sample_q, sample_next;
  logic [CHANNEL_W-1:0] channel_q, channel_next;
  logic                 start_run_c;
  logic                 timeout_hit_c;
  logic                 last_channel_c, last_sample_c;

  logic busy_q, run_done_q, load_req_q, pa_en_q, result_valid_q;
  logic busy_next, run_done_next, load_req_next, pa_en_next, result_valid_next;

  logic [IMAGE_W-1:0] image_base;
  logic [MAP_W-1:0]   map_base;
  logic [PARAM_W-1:0] param_idx;

  assign last_channel_c = (channel_q == CHANNEL_W'(PA_KERNELS_TOTAL - 1));
  assign last_sample_c  = (sample_q  == SAMPLE_W'(NUM_SAMPLES - 1));

  // State and index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      sample_q  <= '0;
      channel_q <= '0;
    end else begin
      state     <= state_next;
      sample_q  <= sample_next;
      channel_q <= channel_next;
    end
  end

  // Next state; abort outranks every handshake in the same cycle
  always_comb begin
    state_next   = state;
    sample_next  = sample_q;
    channel_next = channel_q;
    start_run_c  = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (bus.start) begin
          state_next   = SEQ_LOAD;
          sample_next  = '0;
          channel_next = '0;
          start_run_c  = 1'b1;
        end
      end
      SEQ_LOAD: begin
        if (bus.abort)         state_next = SEQ_IDLE;
        else if (bus.load_ack) state_next = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (bus.abort)        state_next = SEQ_IDLE;
        else if (bus.done_BP) state_next = SEQ_WRITE;
        else if (timeout_hit_c) state_next = SEQ_IDLE;
      end
      SEQ_WRITE: begin
        if (bus.abort)             state_next = SEQ_IDLE;
        else if (bus.result_ready) state_next = SEQ_ADVANCE;
      end
      SEQ_ADVANCE: begin
        if (bus.abort) begin
          state_next = SEQ_IDLE;
        end else if (!last_channel_c) begin
          state_next   = SEQ_LOAD;
          channel_next = channel_q + CHANNEL_W'(1);
        end else if (!last_sample_c) begin
          state_next   = SEQ_LOAD;
          channel_next = '0;
          sample_next  = sample_q + SAMPLE_W'(1);
        end else begin
          state_next = SEQ_IDLE;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Output decode, one cycle ahead so every output leaves a flop
  always_comb begin
    busy_next         = (state_next != SEQ_IDLE);
    load_req_next     = (state_next == SEQ_LOAD);
    pa_en_next        = (state_next == SEQ_RUN);
    result_valid_next = (state_next == SEQ_WRITE);
    run_done_next     = (state == SEQ_ADVANCE) && !bus.abort && last_channel_c && last_sample_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q         <= 1'b0;
      run_done_q     <= 1'b0;
      load_req_q     <= 1'b0;
      pa_en_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      busy_q         <= busy_next;
      run_done_q     <= run_done_next;
      load_req_q     <= load_req_next;
      pa_en_q        <= pa_en_next;
      result_valid_q <= result_valid_next;
    end
  end

`ifdef PA_SEQ_TIMEOUT_EN
  logic [PA_TIMER_W-1:0] run_cnt_q;
  logic                  timeout_err_q;

  // Counts RUN cycles; idles at zero outside RUN so each entry starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    run_cnt_q <= '0;
    else if (state != SEQ_RUN)  run_cnt_q <= '0;
    else                        run_cnt_q <= run_cnt_q + PA_TIMER_W'(1);
  end

  assign timeout_hit_c = (state == SEQ_RUN) &&
                         (run_cnt_q == PA_TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 timeout_err_q <= 1'b0;
    else if (start_run_c)    timeout_err_q <= 1'b0;
    else if (timeout_hit_c && !bus.abort && !bus.done_BP) timeout_err_q <= 1'b1;
  end

  assign bus.timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;

  assign timeout_hit_c      = 1'b0;
  assign unused_timeout_cfg = ^PA_TIMER_W'(TIMEOUT_CYCLES) ^ start_run_c;
  assign bus.timeout_err    = 1'b0;
`endif

  pa_seq_addr_gen #(
    .NUM_SAMPLES        (NUM_SAMPLES),
    .PA_KERNELS_TOTAL   (PA_KERNELS_TOTAL),
    .PA_FMAP_IMAGE_SIZE (PA_FMAP_IMAGE_SIZE),
    .PA_IMAGE_LENGTH    (PA_IMAGE_LENGTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .en         ((state_next == SEQ_LOAD) && (state != SEQ_LOAD)),
    .sample     (sample_next),
    .channel    (channel_next),
    .image_base (image_base),
    .map_base   (map_base),
    .param_idx  (param_idx)
  );

  assign bus.busy         = busy_q;
  assign bus.run_done     = run_done_q;
  assign bus.load_req     = load_req_q;
  assign bus.do_fp        = pa_en_q;
  assign bus.do_bp        = pa_en_q;
  assign bus.result_valid = result_valid_q;
  assign bus.sample_idx   = sample_q;
  assign bus.channel_idx  = channel_q;
  assign bus.image_base   = image_base;
  assign bus.map_base     = map_base;
  assign bus.param_idx    = param_idx;

endmodule

// File: tb/tb_pa_channel_sequencer.sv
// Self-checking bench for pa_channel_sequencer: randomized handshake timing
// checked against pair order and address formulas computed in the bench.
module tb_pa_channel_sequencer;

  localparam int unsigned NS   = 4;
  localparam int unsigned NK   = 6;
  localparam int unsigned FMAP = 784;
  localparam int unsigned ILEN = 784;
  localparam int unsigned TMO  = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pa_channel_sequencer_if #(
    .NUM_SAMPLES(NS), .PA_KERNELS_TOTAL(NK),
    .PA_FMAP_IMAGE_SIZE(FMAP), .PA_IMAGE_LENGTH(ILEN)
  ) bus ();

  pa_channel_sequencer #(
    .NUM_SAMPLES(NS), .PA_KERNELS_TOTAL(NK),
    .PA_FMAP_IMAGE_SIZE(FMAP), .PA_IMAGE_LENGTH(ILEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Passive observation of run_done pulses and LOAD entries
  int   done_pulses = 0;
  int   load_entries = 0;
  logic load_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.run_done === 1'b1) done_pulses++;
    if (bus.load_req === 1'b1 && load_prev !== 1'b1) load_entries++;
    load_prev = bus.load_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First LOAD cycle of pair (s,c): addresses follow directly from the pair
  task automatic check_entry(input int s, input int c);
    int p;
    p = s * NK + c;
    check("entry_ctrl", {bus.busy, bus.load_req, bus.do_fp, bus.result_valid, bus.run_done},
          5'b11000);
    check("entry_sample", bus.sample_idx, s);
    check("entry_channel", bus.channel_idx, c);
    check("entry_param", bus.param_idx, p);
    check("entry_image", bus.image_base, s * ILEN);
    check("entry_map", bus.map_base, p * FMAP);
  endtask

  // Drives one pair from its first LOAD cycle to the end of ADVANCE
  task automatic run_pair(input int s, input int c, input int lw, input int rl, input int rw,
                          input bit spur, input bit poke, input bit abrt, input bit rstw,
                          input bit last);
    int vcyc;
    int d0;
    check_entry(s, c);
    for (int i = 0; i < lw; i++) begin
      bus.done_BP = spur && (i == 0);
      tick();
      check("load_hold", {bus.load_req, bus.do_fp}, 2'b10);
    end
    bus.done_BP  = 1'b0;
    bus.load_ack = 1'b1;
    tick();
    bus.load_ack = 1'b0;
    check("run_en", {bus.do_fp, bus.do_bp, bus.load_req}, 3'b110);
    if (abrt) begin
      d0 = done_pulses;
      bus.abort   = 1'b1;
      bus.done_BP = 1'b1;
      tick();
      bus.abort   = 1'b0;
      bus.done_BP = 1'b0;
      check("abort_ctrl", {bus.busy, bus.do_fp, bus.result_valid, bus.load_req}, 4'b0000);
      repeat (3) begin
        tick();
        check("abort_idle", {bus.busy, bus.run_done}, 2'b00);
      end
      check("abort_sample", bus.sample_idx, s);
      check("abort_channel", bus.channel_idx, c);
      check("abort_no_done", done_pulses - d0, 0);
      return;
    end
    for (int i = 1; i < rl; i++) begin
      bus.start = poke && (i == 1);
      tick();
      bus.start = 1'b0;
      check("run_hold", {bus.do_fp, bus.do_bp, bus.result_valid}, 3'b110);
    end
    bus.done_BP = 1'b1;
    tick();
    bus.done_BP = 1'b0;
    check("write_valid", {bus.result_valid, bus.do_fp, bus.do_bp}, 3'b100);
    if (rstw) begin
      #1 rst = 1'b1;
      #1;
      check("rst_ctrl", {bus.busy, bus.run_done, bus.load_req, bus.do_fp, bus.do_bp,
                         bus.result_valid, bus.timeout_err}, 0);
      check("rst_idx", {bus.sample_idx, bus.channel_idx}, 0);
      check("rst_map", bus.map_base, 0);
      check("rst_param", {bus.param_idx, bus.image_base}, 0);
      tick();
      rst = 1'b0;
      return;
    end
    vcyc = 1;
    for (int i = 0; i < rw; i++) begin
      tick();
      if (bus.result_valid) vcyc++;
      check("write_param", bus.param_idx, s * NK + c);
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("valid_cycles", vcyc, rw + 1);
    check("advance", {bus.busy, bus.result_valid, bus.load_req, bus.run_done}, 4'b1000);
    tick();
    if (last) begin
      check("run_done", {bus.run_done, bus.busy}, 2'b10);
      tick();
      check("run_done_clr", bus.run_done, 0);
    end
  endtask

  initial begin
    int d0, l0, lw, rw;
    bit spur, stop;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.load_ack = 1'b0;
    bus.done_BP = 1'b0; bus.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {bus.busy, bus.run_done, bus.load_req, bus.do_fp, bus.do_bp,
                         bus.result_valid, bus.timeout_err}, 0);
    check("reset_addr", {bus.map_base, bus.image_base, bus.param_idx}, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", bus.busy, 0);

    // Run 1: zero-wait handshakes, 10-cycle PA latency
    d0 = done_pulses; l0 = load_entries;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NK; c++)
        run_pair(s, c, 0, 10, 0, 0, 0, 0, 0, (s == NS - 1) && (c == NK - 1));
    check("run1_loads", load_entries - l0, NS * NK);
    check("run1_done", done_pulses - d0, 1);
    check("run1_last_map", bus.map_base, 18032);
    check("run1_timeout", bus.timeout_err, 0);

    // Run 2: random waits, backpressure on (2,3), spurious done_BP, start while busy
    d0 = done_pulses; l0 = load_entries;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NK; c++) begin
        spur = ($urandom_range(0, 1) == 1);
        lw   = spur ? $urandom_range(1, 3) : $urandom_range(0, 3);
        rw   = (s == 2 && c == 3) ? 7 : $urandom_range(0, 3);
        run_pair(s, c, lw, $urandom_range(1, 12), rw, spur, ($urandom_range(0, 1) == 1),
                 0, 0, (s == NS - 1) && (c == NK - 1));
      end
    check("run2_loads", load_entries - l0, NS * NK);
    check("run2_done", done_pulses - d0, 1);

    // Run 3: abort during RUN of (1,4), then restart from (0,0)
    d0 = done_pulses;
    stop = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int s = 0; s < NS && !stop; s++)
      for (int c = 0; c < NK && !stop; c++) begin
        stop = (s == 1 && c == 4);
        run_pair(s, c, $urandom_range(0, 2), $urandom_range(1, 6), $urandom_range(0, 2),
                 0, 0, stop, 0, 0);
      end
    check("run3_no_done", done_pulses - d0, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_pair(0, 0, 1, 3, 1, 0, 0, 0, 0, 0);
    run_pair(0, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    run_pair(0, 2, 0, 4, 0, 0, 0, 0, 1, 0);
    tick();
    check("post_rst_idle", {bus.busy, bus.load_req, bus.run_done}, 0);
    check("post_rst_map", bus.map_base, 0);

`ifdef PA_SEQ_TIMEOUT_EN
    begin
      int rcyc;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      bus.load_ack = 1'b1; tick(); bus.load_ack = 1'b0;
      rcyc = 1;
      while (bus.do_fp && rcyc < 300) begin
        tick();
        if (bus.do_fp) rcyc++;
      end
      check("tmo_run_cycles", rcyc, TMO);
      check("tmo_flag", {bus.timeout_err, bus.busy, bus.run_done}, 3'b100);
      tick();
      check("tmo_sticky", bus.timeout_err, 1);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      check("tmo_clear", {bus.timeout_err, bus.load_req}, 2'b01);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("tmo_abort", bus.busy, 0);
    end
`else
    check("timeout_tied", bus.timeout_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
